// File: rtl/spi_sample_transmitter.sv
// spi_sample_transmitter: FIFO-buffered parallel-to-SPI sample serialiser (active-low CS, MSB first)
// Ports:
//   s_clk, reset          shared serial clock, asynchronous active-low reset
//   in_sample/in_valid    upstream sample offer; in_ready = FIFO not full
//   clear_overflow        synchronous clear of the sticky overflow flag
//   spi_chip_select/mosi  registered SPI frame outputs
//   busy, frame_done      FSM activity, one-cycle end-of-frame pulse
//   fifo_count, overflow  queue occupancy, sticky dropped-sample flag
module spi_sample_transmitter #(
  parameter int DATA_WIDTH = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                                 s_clk,
  input  logic                                 reset,
  input  logic [DATA_WIDTH-1:0]                in_sample,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 clear_overflow,
  output logic                                 spi_chip_select,
  output logic                                 spi_mosi,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count,
  output logic                                 overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_WIDTH);
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t state, state_d;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] shreg, shreg_d, head;
  logic [BW-1:0] bit_cnt, bit_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic cs_d, mosi_d, done_d, push, pop;
  assign in_ready = fifo_count < CW'(FIFO_DEPTH);
  assign push = in_valid && in_ready;
  assign head = mem[rd_ptr];
  // a frame starts from IDLE or straight out of an expired gap, whenever data is queued
  assign pop = fifo_count != '0 && (state == IDLE || (state == GAP && gap_cnt == '0));
  assign busy = state != IDLE;
  always_comb begin
    state_d = state;
    shreg_d = shreg;
    bit_d = bit_cnt;
    gap_d = gap_cnt;
    cs_d = spi_chip_select;
    mosi_d = spi_mosi;
    done_d = 1'b0;
    if (pop) begin
      state_d = SHIFT;
      cs_d = 1'b0;
      mosi_d = head[DATA_WIDTH-1];
      shreg_d = head << 1;
      bit_d = BW'(DATA_WIDTH - 1);
    end else if (state == SHIFT && bit_cnt != '0) begin
      mosi_d = shreg[DATA_WIDTH-1];
      shreg_d = shreg << 1;
      bit_d = bit_cnt - BW'(1);
    end else if (state == SHIFT) begin
      state_d = GAP;
      cs_d = 1'b1;
      mosi_d = 1'b0;
      done_d = 1'b1;
      gap_d = GW'(GAP_CYCLES - 1);
    end else if (state == GAP && gap_cnt != '0) begin
      gap_d = gap_cnt - GW'(1);
    end else if (state == GAP) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge s_clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      spi_chip_select <= 1'b1;
      spi_mosi <= 1'b0;
      frame_done <= 1'b0;
      fifo_count <= '0;
      overflow <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      state <= state_d;
      shreg <= shreg_d;
      bit_cnt <= bit_d;
      gap_cnt <= gap_d;
      spi_chip_select <= cs_d;
      spi_mosi <= mosi_d;
      frame_done <= done_d;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
      // a new overflow in the same cycle as a clear takes priority
      overflow <= (in_valid && !in_ready) || (overflow && !clear_overflow);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
    end
  end
  always_ff @(posedge s_clk) begin
    if (push) mem[wr_ptr] <= in_sample;
  end
endmodule

// File: tb/tb_spi_sample_transmitter.sv
// tb_spi_sample_transmitter: randomized cycle-level check against a queue/timeline model, plus a small build
module tb_spi_sample_transmitter;
  localparam int DW = 12;
  localparam int DEPTH = 4;
  localparam int GAP = 2;
  logic s_clk = 1'b0;
  logic reset = 1'b0;
  logic [DW-1:0] in_sample = '0;
  logic in_valid = 1'b0;
  logic clear_overflow = 1'b0;
  logic in_ready, spi_chip_select, spi_mosi, busy, frame_done, overflow;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic reset_b = 1'b0;
  logic [DW-1:0] in_sample_b = '0;
  logic in_valid_b = 1'b0;
  logic clear_b = 1'b0;
  logic in_ready_b, cs_b, mosi_b, busy_b, done_b, overflow_b;
  logic [1:0] count_b;
  int checks = 0;
  int errors = 0;
  always #5 s_clk = ~s_clk;
  spi_sample_transmitter #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
    .s_clk(s_clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid), .in_ready(in_ready),
    .clear_overflow(clear_overflow), .spi_chip_select(spi_chip_select), .spi_mosi(spi_mosi),
    .busy(busy), .frame_done(frame_done), .fifo_count(fifo_count), .overflow(overflow));
  spi_sample_transmitter #(.DATA_WIDTH(DW), .FIFO_DEPTH(2), .GAP_CYCLES(1)) dut_b (
    .s_clk(s_clk), .reset(reset_b), .in_sample(in_sample_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .clear_overflow(clear_b), .spi_chip_select(cs_b), .spi_mosi(mosi_b),
    .busy(busy_b), .frame_done(done_b), .fifo_count(count_b), .overflow(overflow_b));
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // reference: queue of pending samples and a position on the frame timeline
  // (-1 idle, 0..DW-1 bit being sent, DW..DW+GAP-1 inter-frame gap)
  logic [DW-1:0] q[$];
  logic [DW-1:0] cur = '0;
  int pos = -1;
  logic m_ovf = 1'b0;
  task automatic model_reset();
    q.delete();
    pos = -1;
    m_ovf = 1'b0;
  endtask
  task automatic model_step();
    bit rdy;
    bit start;
    rdy = q.size() < DEPTH;
    if (in_valid && !rdy) m_ovf = 1'b1;
    else if (clear_overflow) m_ovf = 1'b0;
    start = q.size() > 0 && (pos < 0 || pos == DW + GAP - 1);
    if (start) begin
      cur = q.pop_front();
      pos = 0;
    end else if (pos >= 0) begin
      pos = (pos == DW + GAP - 1) ? -1 : pos + 1;
    end
    if (in_valid && rdy) q.push_back(in_sample);
  endtask
  task automatic compare();
    bit inf;
    logic exp_mosi;
    inf = pos >= 0 && pos < DW;
    exp_mosi = inf ? cur[DW-1-pos] : 1'b0;
    check("cs", spi_chip_select, !inf);
    check("mosi", spi_mosi, exp_mosi);
    check("frame_done", frame_done, pos == DW);
    check("busy", busy, pos >= 0);
    check("fifo_count", fifo_count, q.size());
    check("overflow", overflow, m_ovf);
    check("in_ready", in_ready, q.size() < DEPTH);
  endtask
  task automatic tick();
    @(posedge s_clk);
    if (!reset) model_reset();
    else model_step();
    #1;
    compare();
  endtask
  // small build: frame receiver checking data order, frame length and the 1-cycle gap
  logic [DW-1:0] exp_b[$];
  logic [DW-1:0] sh_b = '0;
  logic prev_cs_b = 1'b1;
  int nbits_b = 0;
  int gap_b = 0;
  int frames_b = 0;
  int e_b;
  bit seen_b = 0;
  bit small_done = 0;
  always @(negedge s_clk) begin
    if (reset_b) begin
      if (!cs_b) begin
        if (prev_cs_b) begin
          if (seen_b) check("b_gap", gap_b, 1);
          nbits_b = 0;
        end
        sh_b = {sh_b[DW-2:0], mosi_b};
        nbits_b++;
      end else begin
        if (!prev_cs_b) begin
          e_b = exp_b.size() > 0 ? int'(exp_b.pop_front()) : -1;
          check("b_bits", nbits_b, DW);
          check("b_data", sh_b, e_b);
          frames_b++;
          seen_b = 1;
          gap_b = 0;
        end
        gap_b++;
      end
      prev_cs_b = cs_b;
    end
  end
  initial begin
    repeat (3) @(posedge s_clk);
    #1 reset_b = 1'b1;
    @(posedge s_clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      if (k >= 2) begin
        repeat (12) @(posedge s_clk);
        #1;
      end
      in_valid_b = 1'b1;
      in_sample_b = DW'($urandom);
      exp_b.push_back(in_sample_b);
      @(posedge s_clk);
      #1 in_valid_b = 1'b0;
    end
    for (int i = 0; i < 100 && frames_b < 10; i++) @(posedge s_clk);
    check("b_frames", frames_b, 10);
    check("b_overflow", overflow_b, 1'b0);
    small_done = 1;
  end
  initial begin
    logic [DW-1:0] vals[4];
    vals = '{12'h000, 12'hFFF, 12'h800, 12'h001};
    repeat (3) @(posedge s_clk);
    #1;
    model_reset();
    compare();
    reset = 1'b1;
    repeat (2) tick();
    in_valid = 1'b1;
    in_sample = 12'hA5C;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    foreach (vals[i]) begin
      in_valid = 1'b1;
      in_sample = vals[i];
      tick();
    end
    in_valid = 1'b0;
    repeat (60) tick();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_sample = DW'(12'h100 + i);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    repeat (70) tick();
    for (int i = 0; i < 800; i++) begin
      in_valid = $urandom_range(0, 99) < 40;
      in_sample = DW'($urandom);
      clear_overflow = $urandom_range(0, 31) == 0;
      tick();
    end
    in_valid = 1'b0;
    clear_overflow = 1'b0;
    repeat (80) tick();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_sample = DW'($urandom);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 40 && pos != 5; i++) tick();
    #3 reset = 1'b0;
    #1;
    model_reset();
    compare();
    repeat (2) tick();
    reset = 1'b1;
    tick();
    in_valid = 1'b1;
    in_sample = 12'h5A3;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    for (int i = 0; i < 500 && !small_done; i++) @(posedge s_clk);
    check("small_done", small_done, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
